// File: rtl/traffic_controller.sv
// rtl/traffic_controller.sv - two-way traffic light sequencer with tick divider.
// Optional one-shot green extension is built when TRAFFIC_EXTENSION_EN is defined.
module traffic_controller #(
  parameter int TICK_DIV    = 100000000,
  parameter int GREEN_TIME  = 10,
  parameter int YELLOW_TIME = 3,
  parameter int RED_TIME    = 1,
  parameter int EXT_TIME    = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic extension,
  output logic tick,
  output logic ns_green,
  output logic ns_yellow,
  output logic ns_red,
  output logic ew_green,
  output logic ew_yellow,
  output logic ew_red
);

  localparam int CW   = $clog2(TICK_DIV);
  localparam int MAXD = GREEN_TIME + EXT_TIME + YELLOW_TIME + RED_TIME;
  localparam int PW   = ($clog2(MAXD + 1) > 8) ? $clog2(MAXD + 1) : 8;

  localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] G_LAST   = PW'(GREEN_TIME - 1);
  localparam logic [PW-1:0] GE_LAST  = PW'(GREEN_TIME + EXT_TIME - 1);
  localparam logic [PW-1:0] Y_LAST   = PW'(YELLOW_TIME - 1);
  localparam logic [PW-1:0] R_LAST   = PW'(RED_TIME - 1);

  typedef enum logic [2:0] {
    S_NS_GREEN, S_NS_YELLOW, S_RED1, S_EW_GREEN, S_EW_YELLOW, S_RED2
  } state_t;

  logic [CW-1:0] div_cnt, div_next;
  state_t        state, state_next;
  logic [PW-1:0] phase, phase_next, phase_last;
  logic          advance;
  logic          ext_add;

  // tick is registered so it is high exactly while div_cnt sits at its last value
  always_comb div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      tick    <= (div_next == DIV_LAST);
    end
  end

`ifdef TRAFFIC_EXTENSION_EN
  logic granted, granted_next, ext_now;

  assign ext_now = tick & extension & ~granted &
                   ((state == S_NS_GREEN) | (state == S_EW_GREEN));
  assign ext_add = granted | ext_now;

  always_comb begin
    granted_next = granted;
    if (advance)      granted_next = 1'b0;
    else if (ext_now) granted_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) granted <= 1'b0;
    else        granted <= granted_next;
  end
`else
  logic unused_extension;
  assign unused_extension = extension;
  assign ext_add = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_NS_GREEN;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    phase_last = R_LAST;
    case (state)
      S_NS_GREEN, S_EW_GREEN:   phase_last = ext_add ? GE_LAST : G_LAST;
      S_NS_YELLOW, S_EW_YELLOW: phase_last = Y_LAST;
      default:                  phase_last = R_LAST;
    endcase
    advance = tick && (phase == phase_last);
    if (tick) begin
      if (advance) begin
        phase_next = '0;
        case (state)
          S_NS_GREEN:  state_next = S_NS_YELLOW;
          S_NS_YELLOW: state_next = S_RED1;
          S_RED1:      state_next = S_EW_GREEN;
          S_EW_GREEN:  state_next = S_EW_YELLOW;
          S_EW_YELLOW: state_next = S_RED2;
          default:     state_next = S_NS_GREEN;
        endcase
      end else begin
        phase_next = phase + 1'b1;
      end
    end
  end

  always_comb begin
    ns_green  = 1'b0;
    ns_yellow = 1'b0;
    ns_red    = 1'b1;
    ew_green  = 1'b0;
    ew_yellow = 1'b0;
    ew_red    = 1'b1;
    case (state)
      S_NS_GREEN:  begin ns_green  = 1'b1; ns_red = 1'b0; end
      S_NS_YELLOW: begin ns_yellow = 1'b1; ns_red = 1'b0; end
      S_EW_GREEN:  begin ew_green  = 1'b1; ew_red = 1'b0; end
      S_EW_YELLOW: begin ew_yellow = 1'b1; ew_red = 1'b0; end
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_traffic_controller.sv
// tb/tb_traffic_controller.sv - randomized bench for traffic_controller against a tick-level model.
// Expected extension behaviour follows TRAFFIC_EXTENSION_EN.
module tb_traffic_controller;

  localparam int TD = 10;
  localparam int G  = 10;
  localparam int Y  = 3;
  localparam int R  = 1;
  localparam int E  = 5;
`ifdef TRAFFIC_EXTENSION_EN
  localparam int G_EXT = G + E;
`else
  localparam int G_EXT = G;
`endif

  logic clk, reset, extension;
  logic tick, ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
  wire [5:0] lamps = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};

  int total, bad;
  int m_cyc, m_ph, m_rem;
`ifdef TRAFFIC_EXTENSION_EN
  bit m_granted;
`endif

  traffic_controller #(
    .TICK_DIV(TD), .GREEN_TIME(G), .YELLOW_TIME(Y), .RED_TIME(R), .EXT_TIME(E)
  ) dut (
    .clk(clk), .reset(reset), .extension(extension), .tick(tick),
    .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
    .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phases: 0 NS green, 1 NS yellow, 2 all red, 3 EW green, 4 EW yellow, 5 all red
  function automatic logic [5:0] lamps_of(int ph);
    case (ph)
      0:       return 6'b100_001;
      1:       return 6'b010_001;
      3:       return 6'b001_100;
      4:       return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  function automatic int dur_of(int ph);
    if (ph == 0 || ph == 3) return G;
    if (ph == 1 || ph == 4) return Y;
    return R;
  endfunction

  function automatic logic exp_tick();
    return (m_cyc % TD) == TD - 1;
  endfunction

  task automatic model_init();
    m_cyc = 0;
    m_ph  = 0;
    m_rem = G;
`ifdef TRAFFIC_EXTENSION_EN
    m_granted = 0;
`endif
  endtask

  // one clock: model consumes the tick/extension seen before the edge, returns at negedge
  task automatic step();
    logic tp, ep;
    tp = exp_tick();
    ep = extension;
    @(posedge clk);
    m_cyc++;
    if (tp) begin
`ifdef TRAFFIC_EXTENSION_EN
      if ((m_ph == 0 || m_ph == 3) && ep && !m_granted) begin
        m_rem += E;
        m_granted = 1;
      end
`endif
      m_rem--;
      if (m_rem == 0) begin
        m_ph  = (m_ph + 1) % 6;
        m_rem = dur_of(m_ph);
`ifdef TRAFFIC_EXTENSION_EN
        m_granted = 0;
`endif
      end
    end
    @(negedge clk);
    if (ep === 1'bx) $display("warning: extension undriven");
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    extension = 1'b0;
    model_init();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    model_init();
  endtask

  task automatic test_reset();
    hold_reset();
    total++;
    if (lamps !== 6'b100_001) begin bad++; $display("FAIL reset_lamps: got %b want %b", lamps, 6'b100_001); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    extension = 1'b1;
    repeat (TD + 3) @(negedge clk);
    total++;
    if (lamps !== 6'b100_001 || tick !== 1'b0) begin
      bad++; $display("FAIL reset_held: lamps %b tick %b want 100001 0", lamps, tick);
    end
    extension = 1'b0;
    release_reset();
  endtask

  task automatic test_tick_cycle();
    int first;
    first = -1;
    hold_reset();
    release_reset();
    for (int i = 0; i < 300; i++) begin
      if (tick === 1'b1 && first < 0) first = m_cyc;
      total++;
      if (tick !== exp_tick()) begin bad++; $display("FAIL tick_cyc%0d: got %b want %b", m_cyc, tick, exp_tick()); end
      total++;
      if (lamps !== lamps_of(m_ph)) begin bad++; $display("FAIL seq_lamps_cyc%0d: got %b want %b", m_cyc, lamps, lamps_of(m_ph)); end
      total++;
      if (!ns_red && !ew_red) begin bad++; $display("FAIL exclusive_cyc%0d: got ns_red=0 ew_red=0 want one red", m_cyc); end
      if (m_cyc == 270) begin
        total++;
        if (lamps !== 6'b001_001) begin bad++; $display("FAIL red2_at_27_ticks: got %b want 001001", lamps); end
      end
      if (m_cyc == 280) begin
        total++;
        if (lamps !== 6'b100_001) begin bad++; $display("FAIL wrap_at_28_ticks: got %b want 100001", lamps); end
      end
      step();
    end
    total++;
    if (first != TD - 1) begin bad++; $display("FAIL first_tick: got cycle %0d want %0d", first, TD - 1); end
  endtask

  task automatic test_ext_pulse();
    int ticks;
    bit done;
    ticks = 0;
    done = 0;
    hold_reset();
    release_reset();
    for (int c = 0; c < 600 && !done; c++) begin
      if (exp_tick()) begin
        ticks++;
        extension = (ticks == 6);
      end else begin
        extension = 1'b0;
      end
      step();
      if (!ns_green) done = 1;
    end
    extension = 1'b0;
    total++;
    if (!done || ticks != G_EXT) begin bad++; $display("FAIL ext_pulse_green: got %0d ticks want %0d", ticks, G_EXT); end
    total++;
    if (lamps !== 6'b010_001) begin bad++; $display("FAIL ext_pulse_next: got %b want 010001", lamps); end
    for (int i = 0; i < 200; i++) begin
      total++;
      if (lamps !== lamps_of(m_ph)) begin bad++; $display("FAIL ext_pulse_seq_cyc%0d: got %b want %b", m_cyc, lamps, lamps_of(m_ph)); end
      step();
    end
  endtask

  task automatic test_ext_held();
    int ticks;
    bit done;
    ticks = 0;
    done = 0;
    hold_reset();
    release_reset();
    extension = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      if (exp_tick()) ticks++;
      step();
      if (!ns_green) done = 1;
    end
    extension = 1'b0;
    total++;
    if (!done || ticks != G_EXT) begin bad++; $display("FAIL ext_held_green: got %0d ticks want %0d", ticks, G_EXT); end
    for (int i = 0; i < 200; i++) begin
      total++;
      if (lamps !== lamps_of(m_ph)) begin bad++; $display("FAIL ext_held_seq_cyc%0d: got %b want %b", m_cyc, lamps, lamps_of(m_ph)); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int ticks;
    bit found, done;
    found = 0;
    done = 0;
    ticks = 0;
    hold_reset();
    release_reset();
    for (int c = 0; c < 400 && !found; c++) begin
      if (m_ph == 4 && exp_tick()) found = 1;
      else step();
    end
    total++;
    if (!found || tick !== 1'b1 || lamps !== 6'b001_010) begin
      bad++; $display("FAIL reach_ew_yellow: got lamps %b tick %b want 001010 1", lamps, tick);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (lamps !== 6'b100_001 || tick !== 1'b0) begin
      bad++; $display("FAIL async_reset: got lamps %b tick %b want 100001 0", lamps, tick);
    end
    model_init();
    @(negedge clk);
    release_reset();
    for (int c = 0; c < 400 && !done; c++) begin
      if (exp_tick()) ticks++;
      step();
      if (!ns_green) done = 1;
    end
    total++;
    if (!done || ticks != G) begin bad++; $display("FAIL green_after_reset: got %0d ticks want %0d", ticks, G); end
  endtask

  task automatic test_random();
    hold_reset();
    release_reset();
    for (int i = 0; i < 1500; i++) begin
      total++;
      if (tick !== exp_tick()) begin bad++; $display("FAIL rand_tick_cyc%0d: got %b want %b", m_cyc, tick, exp_tick()); end
      total++;
      if (lamps !== lamps_of(m_ph)) begin bad++; $display("FAIL rand_lamps_cyc%0d: got %b want %b", m_cyc, lamps, lamps_of(m_ph)); end
      total++;
      if (!ns_red && !ew_red) begin bad++; $display("FAIL rand_exclusive_cyc%0d: got ns_red=0 ew_red=0 want one red", m_cyc); end
      extension = ($urandom_range(0, 7) == 0);
      step();
    end
    extension = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    extension = 1'b0;
    model_init();
    test_reset();
    test_tick_cycle();
    test_ext_pulse();
    test_ext_held();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/traffic_controller.md
TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 The block SHALL expose parameter TICK_DIV, default 100000000, meaning clock cycles per tick (≥2).
REQ-002 The block SHALL expose parameter GREEN_TIME, default 10, meaning green duration in ticks (≥1).
REQ-003 The block SHALL expose parameter YELLOW_TIME, default 3, meaning yellow duration in ticks (≥1).
REQ-004 The block SHALL expose parameter RED_TIME, default 1, meaning all-red clearance in ticks (≥1).
REQ-005 The block SHALL expose parameter EXT_TIME, default 5, meaning extra green ticks granted by extension (≥1).
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-009 Port extension, input, 1 bit: synchronous request to lengthen the current green phase.
REQ-010 Port tick, output, 1 bit: one-clk-cycle strobe, once per TICK_DIV cycles.
REQ-011 Ports ns_green, ns_yellow, ns_red, output, 1 bit each: north-south lamps, exactly one high.
REQ-012 Ports ew_green, ew_yellow, ew_red, output, 1 bit each: east-west lamps, exactly one high.

Function
REQ-013 Tick divider: counter 0..TICK_DIV-1, increments every clk, wraps to 0; tick=1 exactly in the cycle counter==TICK_DIV-1, registered.
REQ-014 First tick after reset release SHALL occur on the TICK_DIV-th rising edge; thereafter period exactly TICK_DIV cycles, 1-cycle high.
REQ-015 Light FSM states, fixed order: NS_GREEN -> NS_YELLOW -> RED1 -> EW_GREEN -> EW_YELLOW -> RED2 -> NS_GREEN.
REQ-016 Phase counter (≥8 bits) advances only on clk edges where tick=1; state changes only on such edges.
REQ-017 A state of duration D SHALL last exactly D ticks: on a tick with phase counter==D-1, advance state and clear counter; else increment.
REQ-018 Durations: green states GREEN_TIME (+EXT_TIME if extended), yellow states YELLOW_TIME, RED1/RED2 RED_TIME.
REQ-019 Lamp decode (Moore, from registered state): NS_GREEN → ns_green, ew_red; NS_YELLOW → ns_yellow, ew_red; RED1/RED2 → ns_red, ew_red; EW_GREEN → ns_red, ew_green; EW_YELLOW → ns_red, ew_yellow.
REQ-020 Never both directions non-red simultaneously.
REQ-021 Extension sampled only on tick edges in a green state; if extension=1 there and no extension granted this phase, current green duration becomes GREEN_TIME+EXT_TIME.
REQ-022 At most one extension per green phase; grant flag clears on entry to each green state.
REQ-023 Extension on the tick that ends green (counter==GREEN_TIME-1, not yet extended) SHALL be granted and green continues; extension outside green or between ticks is ignored.
REQ-024 Extension held high continuously grants only one EXT_TIME.

Reset
REQ-025 While reset=0: divider counter=0, tick=0, state=NS_GREEN, phase counter=0, grant flag=0, outputs ns_green=1, ew_red=1, all other lamps 0.
REQ-026 Reset asserted mid-phase SHALL immediately (asynchronously) force the reset values above; operation resumes from NS_GREEN with full timing after release.

Configuration
REQ-027 Macro TRAFFIC_EXTENSION_EN defined: extension behaves per REQ-021..024.
REQ-028 Macro TRAFFIC_EXTENSION_EN undefined: extension port still present but ignored; every green lasts exactly GREEN_TIME ticks; no grant-flag logic.

Verification (TICK_DIV=10, GREEN_TIME=10, YELLOW_TIME=3, RED_TIME=1, EXT_TIME=5)
REQ-029 Release reset, count clk -> tick first high on 10th edge, then every 10 cycles, width 1 cycle.
REQ-030 No extension -> NS green 10 ticks, NS yellow 3, all-red 1, EW green 10, EW yellow 3, all-red 1, back to NS_GREEN after 28 ticks.
REQ-031 Macro defined, extension=1 for one tick at the 6th tick after reset -> NS green lasts 15 ticks, then normal sequence.
REQ-032 Extension held high across a whole green -> green lasts 15 ticks exactly, not longer.
REQ-033 Macro undefined, same stimulus as REQ-031 -> NS green lasts 10 ticks.
REQ-034 Assert reset during EW_YELLOW -> same cycle ns_green=1, ew_red=1, tick=0; full 10-tick NS green after release.
